core_buf_loader: RTL and testbench
==================================

Name: core_buf_loader

Overview:
Upstream loader for the diff core's activation-side buffers. It accepts a load command plus a stream of 72-bit words and scatters the words round-robin across the per-column feature-map or guard buffers through the core's load_fm_*/load_gd_* write ports. When the command asks for it, the block then launches the core with a valid/ready kick and waits for core_finish. This gives the system controller one command/stream interface per layer.

Parameters:
COL_NUM, 4, number of PE columns (matches CONF_PE_COL)
FM_DEPTH, 256, words per column feature-map buffer (matches CONF_FM_BUF_DEPTH)
GD_DEPTH, 64, words per column guard buffer (matches CONF_GUARD_BUF_DEPTH)
FM_AW, $clog2(FM_DEPTH), feature-map address width
GD_AW, $clog2(GD_DEPTH), guard address width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_target  in  1  0 = fm buffers, 1 = guard buffers
cmd_base  in  FM_AW  first row address; for guard, only bits [GD_AW-1:0] are used
cmd_rows_m1  in  8  rows per column minus 1
cmd_cols  in  $clog2(COL_NUM)+1  columns used, legal range 1..COL_NUM
cmd_start  in  1  launch the core after the load
cmd_bit_mode  in  1  bit mode forwarded to the core
cmd_is_diff  in  1  diff flag forwarded to the core
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid&s_ready
s_data  in  72  stream word
load_fm_wr_addr  out  COL_NUM x FM_AW  fm write address per column
load_fm_din  out  COL_NUM x 72  fm write data per column
load_fm_wr_en  out  COL_NUM  fm write enable per column
load_gd_wr_addr  out  COL_NUM x GD_AW  guard write address per column
load_gd_din  out  COL_NUM x 72  guard write data per column
load_gd_wr_en  out  COL_NUM  guard write enable per column
core_valid  out  1  core start request
core_ready  in  1  core accepts the start
core_bit_mode_i  out  1  latched cmd_bit_mode, held stable from KICK through WAIT_FIN
core_is_diff_i  out  1  latched cmd_is_diff, held stable from KICK through WAIT_FIN
core_finish  in  1  core completion pulse
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-command pulse

Behaviour:
- Reset: every output is 0 and the FSM returns to IDLE.
  - Reset mid-load abandons the command.
  - Words already written stay in the buffers.
  - Any pending core_valid is dropped.
- FSM states: IDLE, LOAD, KICK, WAIT_FIN.
- IDLE:
  - cmd_ready=1 and s_ready=0.
  - On cmd handshake, all cmd fields are latched.
  - The command is illegal if any of these hold: cmd_cols==0; cmd_cols>COL_NUM; base+rows_m1 >= depth of the target buffer (FM_DEPTH or GD_DEPTH), computed at 9+ bits with no wrap.
  - Illegal command: err pulses the next cycle, FSM stays in IDLE, no write and no done.
  - Legal command: go to LOAD with col=0, row=0.
- LOAD:
  - cmd_ready=0; s_ready=1 in every LOAD cycle (the write ports never stall).
  - Each accepted beat produces a registered write on the next cycle for exactly one cycle: wr_en[col]=1 on the target bank, addr=base+row, din=s_data. This is 1-cycle latency.
  - The other bank's enables and the other columns' enables stay 0.
  - Addr/din of idle columns hold their last values.
  - After each beat, col increments. When col==cmd_cols-1, col wraps to 0 and row increments.
  - Beat order: word k goes to column k mod cmd_cols, row k div cmd_cols.
  - Total beats per command = (rows_m1+1)*cmd_cols.
  - Last beat accepted with cmd_start=0: go to IDLE. done pulses in the same cycle as the last write enable.
  - Last beat accepted with cmd_start=1: go to KICK. core_valid rises in the same cycle as the last write enable.
  - s_ready drops the cycle after the last beat is accepted.
- KICK:
  - core_valid=1 and held until core_valid&core_ready is sampled, then go to WAIT_FIN.
  - core_valid=0 from WAIT_FIN onward.
  - core_ready while core_valid=0 is ignored.
- WAIT_FIN:
  - A core_finish pulse causes done the next cycle and a return to IDLE.
  - core_finish in IDLE, LOAD or KICK is ignored.
  - core_finish in the same cycle as the KICK handshake is ignored; only a finish strictly after the handshake counts.
- Back-to-back: a new command is accepted in the same cycle done pulses, because the FSM is already in IDLE.
- Maximum size: rows_m1=255 with base=0 into FM_DEPTH=256 is legal and writes rows 0..255.

Test Plan:
1. fm cmd, base=10, rows_m1=1, cols=4, start=0; 8 words D0..D7 back-to-back -> col j gets D(j) at addr 10 and D(j+4) at addr 11; load_gd_wr_en stays 0; done once, in the cycle of the D7 write.
2. Guard cmd, base=60, rows_m1=3, GD_DEPTH=64 (ends at 63) -> accepted. Same cmd with base=61 -> err pulse, no writes, busy stays 0.
3. cmd_cols=0, then cmd_cols=5 -> err each time. Then a legal cols=3 cmd with 6 words -> only columns 0..2 written, 2 rows each.
4. fm cmd, start=1, bit_mode=1, is_diff=1, 4 words, core_ready held low 5 cycles then high -> core_valid high for exactly 6 cycles; core_bit_mode_i=1 and core_is_diff_i=1. core_finish pulsed 3 cycles later -> done 1 cycle after finish, then IDLE.
5. s_valid toggled randomly during a 12-word load -> write order and addresses identical to the back-to-back case. A spurious core_finish during LOAD has no effect.
6. rst_n asserted after 3 of 8 beats -> all outputs 0 immediately. A fresh command is then accepted in IDLE and completes normally.

Source files
------------

// File: rtl/core_buf_loader.sv
// core_buf_loader
// Takes one command plus a stream of 72-bit words per layer. It scatters the
// words round-robin across the per-column feature-map or guard buffers of the
// diff core. When the command asks for it, it then kicks the core with a
// valid/ready start and waits for core_finish.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_*                 command channel (valid/ready), fields latched on accept
//   s_valid/s_ready/s_data  word stream, one word per accepted beat
//   load_fm_*             per-column feature-map write ports (flattened, col 0 in LSBs)
//   load_gd_*             per-column guard write ports (flattened, col 0 in LSBs)
//   core_valid/core_ready start handshake towards the core
//   core_bit_mode_i, core_is_diff_i  latched command flags for the core
//   core_finish           completion pulse from the core
//   busy, done, err       status: not idle, completion pulse, illegal-command pulse
module core_buf_loader #(
  parameter int COL_NUM  = 4,
  parameter int FM_DEPTH = 256,
  parameter int GD_DEPTH = 64,
  parameter int FM_AW    = $clog2(FM_DEPTH),
  parameter int GD_AW    = $clog2(GD_DEPTH),
  localparam int CW      = $clog2(COL_NUM) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_target,
  input  logic [FM_AW-1:0]         cmd_base,
  input  logic [7:0]               cmd_rows_m1,
  input  logic [CW-1:0]            cmd_cols,
  input  logic                     cmd_start,
  input  logic                     cmd_bit_mode,
  input  logic                     cmd_is_diff,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [71:0]              s_data,
  output logic [COL_NUM*FM_AW-1:0] load_fm_wr_addr,
  output logic [COL_NUM*72-1:0]    load_fm_din,
  output logic [COL_NUM-1:0]       load_fm_wr_en,
  output logic [COL_NUM*GD_AW-1:0] load_gd_wr_addr,
  output logic [COL_NUM*72-1:0]    load_gd_din,
  output logic [COL_NUM-1:0]       load_gd_wr_en,
  output logic                     core_valid,
  input  logic                     core_ready,
  output logic                     core_bit_mode_i,
  output logic                     core_is_diff_i,
  input  logic                     core_finish,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, LOAD, KICK, WAIT_FIN} state_t;

  state_t state, state_nx;

  logic             alive;
  logic             tgt_q;
  logic [FM_AW-1:0] base_q;
  logic [7:0]       rows_q;
  logic [CW-1:0]    cols_q;
  logic             start_q;
  logic [CW-1:0]    col_q;
  logic [7:0]       row_q;

  logic             cmd_fire;
  logic             beat_fire;
  logic             last_beat;
  logic             cmd_legal;
  logic [31:0]      end_row;
  logic [FM_AW-1:0] fm_addr_nx;
  logic [GD_AW-1:0] gd_addr_nx;

  logic [FM_AW-1:0] fm_addr_q [COL_NUM];
  logic [71:0]      fm_din_q  [COL_NUM];
  logic [GD_AW-1:0] gd_addr_q [COL_NUM];
  logic [71:0]      gd_din_q  [COL_NUM];

  // cmd_ready is held low for the first cycle after reset so that every
  // output really is 0 while rst_n is asserted.
  assign cmd_ready  = alive && (state == IDLE);
  assign s_ready    = (state == LOAD);
  assign core_valid = (state == KICK);
  assign busy       = (state != IDLE);

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign beat_fire  = s_valid && s_ready;
  assign last_beat  = beat_fire && (col_q == cols_q - CW'(1)) && (row_q == rows_q);

  assign fm_addr_nx = FM_AW'(32'(base_q) + 32'(row_q));
  assign gd_addr_nx = GD_AW'(32'(base_q[GD_AW-1:0]) + 32'(row_q));

  // Command legality: the last row must fit in the target buffer. The sum is
  // taken at 32 bits so a large base plus rows cannot wrap back into range.
  always_comb begin
    end_row = cmd_target ? (32'(cmd_base[GD_AW-1:0]) + 32'(cmd_rows_m1))
                         : (32'(cmd_base) + 32'(cmd_rows_m1));
    cmd_legal = (cmd_cols != '0) &&
                (32'(cmd_cols) <= 32'(COL_NUM)) &&
                (end_row < (cmd_target ? 32'(GD_DEPTH) : 32'(FM_DEPTH)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A finish that arrives in the KICK cycle (even the handshake cycle) is
  // ignored because only WAIT_FIN looks at core_finish.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (cmd_fire && cmd_legal) state_nx = LOAD;
      LOAD:     if (last_beat) state_nx = start_q ? KICK : IDLE;
      KICK:     if (core_ready) state_nx = WAIT_FIN;
      WAIT_FIN: if (core_finish) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Command latch, row/column walk and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive           <= 1'b0;
      tgt_q           <= 1'b0;
      base_q          <= '0;
      rows_q          <= '0;
      cols_q          <= '0;
      start_q         <= 1'b0;
      core_bit_mode_i <= 1'b0;
      core_is_diff_i  <= 1'b0;
      col_q           <= '0;
      row_q           <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      alive <= 1'b1;
      done  <= (state == LOAD && last_beat && !start_q) ||
               (state == WAIT_FIN && core_finish);
      err   <= cmd_fire && !cmd_legal;
      if (cmd_fire) begin
        tgt_q           <= cmd_target;
        base_q          <= cmd_base;
        rows_q          <= cmd_rows_m1;
        cols_q          <= cmd_cols;
        start_q         <= cmd_start;
        core_bit_mode_i <= cmd_bit_mode;
        core_is_diff_i  <= cmd_is_diff;
        col_q           <= '0;
        row_q           <= '0;
      end else if (beat_fire) begin
        if (col_q == cols_q - CW'(1)) begin
          col_q <= '0;
          row_q <= row_q + 8'd1;
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  // Registered write ports: an accepted beat becomes a one-cycle write on the
  // next cycle. Idle columns keep their last address and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_fm_wr_en <= '0;
      load_gd_wr_en <= '0;
      for (int c = 0; c < COL_NUM; c++) begin
        fm_addr_q[c] <= '0;
        fm_din_q[c]  <= '0;
        gd_addr_q[c] <= '0;
        gd_din_q[c]  <= '0;
      end
    end else begin
      load_fm_wr_en <= '0;
      load_gd_wr_en <= '0;
      for (int c = 0; c < COL_NUM; c++) begin
        if (beat_fire && col_q == CW'(c)) begin
          if (!tgt_q) begin
            load_fm_wr_en[c] <= 1'b1;
            fm_addr_q[c]     <= fm_addr_nx;
            fm_din_q[c]      <= s_data;
          end else begin
            load_gd_wr_en[c] <= 1'b1;
            gd_addr_q[c]     <= gd_addr_nx;
            gd_din_q[c]      <= s_data;
          end
        end
      end
    end
  end

  for (genvar c = 0; c < COL_NUM; c++) begin : g_flat
    assign load_fm_wr_addr[c*FM_AW +: FM_AW] = fm_addr_q[c];
    assign load_fm_din[c*72 +: 72]           = fm_din_q[c];
    assign load_gd_wr_addr[c*GD_AW +: GD_AW] = gd_addr_q[c];
    assign load_gd_din[c*72 +: 72]           = gd_din_q[c];
  end

endmodule

// File: tb/tb_core_buf_loader.sv
// tb_core_buf_loader
// Self-checking bench for core_buf_loader. A negedge monitor logs every write,
// done and err pulse with its cycle number. Each test task compares the log
// against the loader's rules: word k goes to column k mod cols, row k div cols.
module tb_core_buf_loader;
  localparam int COL_NUM  = 4;
  localparam int FM_DEPTH = 256;
  localparam int GD_DEPTH = 64;
  localparam int FM_AW    = 8;
  localparam int GD_AW    = 6;
  localparam int CW       = 3;

  logic                     clk;
  logic                     rst_n;
  logic                     cmd_valid, cmd_ready, cmd_target;
  logic [FM_AW-1:0]         cmd_base;
  logic [7:0]               cmd_rows_m1;
  logic [CW-1:0]            cmd_cols;
  logic                     cmd_start, cmd_bit_mode, cmd_is_diff;
  logic                     s_valid, s_ready;
  logic [71:0]              s_data;
  logic [COL_NUM*FM_AW-1:0] load_fm_wr_addr;
  logic [COL_NUM*72-1:0]    load_fm_din;
  logic [COL_NUM-1:0]       load_fm_wr_en;
  logic [COL_NUM*GD_AW-1:0] load_gd_wr_addr;
  logic [COL_NUM*72-1:0]    load_gd_din;
  logic [COL_NUM-1:0]       load_gd_wr_en;
  logic                     core_valid, core_ready, core_bit_mode_i, core_is_diff_i;
  logic                     core_finish, busy, done, err;

  typedef struct { bit bank; int col; int addr; logic [71:0] data; int cyc; } wr_t;

  wr_t         wr_q[$];
  int          done_q[$];
  int          err_q[$];
  logic [71:0] words_q[$];
  int          multi_en = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          last_beat_cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  core_buf_loader #(.COL_NUM(COL_NUM), .FM_DEPTH(FM_DEPTH), .GD_DEPTH(GD_DEPTH),
                    .FM_AW(FM_AW), .GD_AW(GD_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_base(cmd_base), .cmd_rows_m1(cmd_rows_m1), .cmd_cols(cmd_cols),
    .cmd_start(cmd_start), .cmd_bit_mode(cmd_bit_mode), .cmd_is_diff(cmd_is_diff),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .load_fm_wr_addr(load_fm_wr_addr), .load_fm_din(load_fm_din), .load_fm_wr_en(load_fm_wr_en),
    .load_gd_wr_addr(load_gd_wr_addr), .load_gd_din(load_gd_din), .load_gd_wr_en(load_gd_wr_en),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_bit_mode_i(core_bit_mode_i), .core_is_diff_i(core_is_diff_i),
    .core_finish(core_finish), .busy(busy), .done(done), .err(err)
  );

  wire any_out = |{cmd_ready, s_ready, load_fm_wr_addr, load_fm_din, load_fm_wr_en,
                   load_gd_wr_addr, load_gd_din, load_gd_wr_en, core_valid,
                   core_bit_mode_i, core_is_diff_i, busy, done, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log writes and pulses in the cycle they are visible.
  always @(negedge clk) begin
    wr_t r;
    for (int c = 0; c < COL_NUM; c++) begin
      if (load_fm_wr_en[c] === 1'b1) begin
        r.bank = 1'b0; r.col = c; r.addr = int'(load_fm_wr_addr[c*FM_AW +: FM_AW]);
        r.data = load_fm_din[c*72 +: 72]; r.cyc = cyc; wr_q.push_back(r);
      end
      if (load_gd_wr_en[c] === 1'b1) begin
        r.bank = 1'b1; r.col = c; r.addr = int'(load_gd_wr_addr[c*GD_AW +: GD_AW]);
        r.data = load_gd_din[c*72 +: 72]; r.cyc = cyc; wr_q.push_back(r);
      end
    end
    if ($countones({load_fm_wr_en, load_gd_wr_en}) > 1) multi_en++;
    if (done === 1'b1) done_q.push_back(cyc);
    if (err === 1'b1) err_q.push_back(cyc);
  end

  // Reference rule for whether a command may be executed.
  function automatic bit model_legal(bit tgt, int base, int rows, int cols);
    int eff;
    eff = tgt ? (base % GD_DEPTH) : base;
    return (cols >= 1) && (cols <= COL_NUM) && (eff + rows < (tgt ? GD_DEPTH : FM_DEPTH));
  endfunction

  task automatic clear_logs;
    @(negedge clk);
    #1;
    wr_q.delete(); done_q.delete(); err_q.delete(); multi_en = 0;
  endtask

  task automatic fill_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back({$urandom, $urandom, 8'($urandom)});
  endtask

  task automatic send_cmd(input bit tgt, input int base, input int rows, input int cols,
                          input bit start, input bit bm, input bit diff);
    int n;
    n = 0;
    @(negedge clk);
    cmd_target = tgt; cmd_base = FM_AW'(base); cmd_rows_m1 = 8'(rows);
    cmd_cols = CW'(cols); cmd_start = start; cmd_bit_mode = bm; cmd_is_diff = diff;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL cmd_accept: cmd_ready got %b, want 1 within 50 cycles", cmd_ready);
    end
    hs_cyc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_words(input int first, input int n, input bit gaps);
    int i, guard;
    i = 0; guard = 0;
    while (i < n && guard < 4000) begin
      @(negedge clk); guard++;
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = words_q[first + i];
      if (s_valid && s_ready === 1'b1) begin last_beat_cyc = cyc + 1; i++; end
    end
    n_cmp++;
    if (i != n) begin n_bad++; $display("[TB] FAIL beats_accepted: got %0d, want %0d", i, n); end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (any_out !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_outputs: got %b, want 0", any_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_idle: cmd_ready=%b busy=%b, want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_fm_basic;
    clear_logs(); fill_words(8);
    send_cmd(1'b0, 10, 1, 4, 1'b0, 1'b0, 1'b0);
    send_words(0, 8, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 8) begin n_bad++; $display("[TB] FAIL fm_basic_count: got %0d, want 8", wr_q.size()); end
    for (int k = 0; k < wr_q.size() && k < 8; k++) begin
      n_cmp++;
      if (wr_q[k].bank !== 1'b0 || wr_q[k].col != k % 4 || wr_q[k].addr != 10 + k / 4 || wr_q[k].data !== words_q[k]) begin
        n_bad++; $display("[TB] FAIL fm_basic_w%0d: got bank%0d col%0d addr%0d data%h, want bank0 col%0d addr%0d data%h",
          k, wr_q[k].bank, wr_q[k].col, wr_q[k].addr, wr_q[k].data, k % 4, 10 + k / 4, words_q[k]);
      end
    end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] != last_beat_cyc || multi_en != 0) begin
      n_bad++; $display("[TB] FAIL fm_basic_done: got %0d dones (first@%0d) multi=%0d, want 1 @%0d multi=0",
        done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, multi_en, last_beat_cyc);
    end
  endtask

  task automatic test_guard_bounds;
    int busy_seen;
    clear_logs(); fill_words(8);
    send_cmd(1'b1, 60, 3, 2, 1'b0, 1'b0, 1'b0);
    send_words(0, 8, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 8) begin n_bad++; $display("[TB] FAIL guard_count: got %0d, want 8", wr_q.size()); end
    for (int k = 0; k < wr_q.size() && k < 8; k++) begin
      n_cmp++;
      if (wr_q[k].bank !== 1'b1 || wr_q[k].col != k % 2 || wr_q[k].addr != 60 + k / 2 || wr_q[k].data !== words_q[k]) begin
        n_bad++; $display("[TB] FAIL guard_w%0d: got bank%0d col%0d addr%0d, want bank1 col%0d addr%0d",
          k, wr_q[k].bank, wr_q[k].col, wr_q[k].addr, k % 2, 60 + k / 2);
      end
    end
    n_cmp++;
    if (done_q.size() != 1) begin n_bad++; $display("[TB] FAIL guard_done: got %0d, want 1", done_q.size()); end
    clear_logs();
    send_cmd(1'b1, 61, 3, 2, 1'b0, 1'b0, 1'b0);
    busy_seen = 0;
    repeat (4) begin @(negedge clk); if (busy !== 1'b0 || s_ready !== 1'b0) busy_seen++; end
    n_cmp++;
    if (err_q.size() != 1 || err_q[0] != hs_cyc) begin
      n_bad++; $display("[TB] FAIL guard_err: got %0d errs (first@%0d), want 1 @%0d",
        err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, hs_cyc);
    end
    n_cmp++;
    if (wr_q.size() != 0 || done_q.size() != 0 || busy_seen != 0) begin
      n_bad++; $display("[TB] FAIL guard_err_quiet: writes=%0d dones=%0d busy_cycles=%0d, want 0/0/0",
        wr_q.size(), done_q.size(), busy_seen);
    end
  endtask

  task automatic test_bad_cols;
    int hs0, hs1;
    clear_logs();
    send_cmd(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0); hs0 = hs_cyc;
    send_cmd(1'b0, 0, 0, 5, 1'b0, 1'b0, 1'b0); hs1 = hs_cyc;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (err_q.size() != 2 || err_q[0] != hs0 || err_q[1] != hs1 || wr_q.size() != 0) begin
      n_bad++; $display("[TB] FAIL bad_cols_err: got %0d errs %0d writes, want 2 errs @%0d,%0d and 0 writes",
        err_q.size(), wr_q.size(), hs0, hs1);
    end
    clear_logs(); fill_words(6);
    send_cmd(1'b0, 100, 1, 3, 1'b0, 1'b0, 1'b0);
    send_words(0, 6, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 6) begin n_bad++; $display("[TB] FAIL cols3_count: got %0d, want 6", wr_q.size()); end
    for (int k = 0; k < wr_q.size() && k < 6; k++) begin
      n_cmp++;
      if (wr_q[k].bank !== 1'b0 || wr_q[k].col != k % 3 || wr_q[k].addr != 100 + k / 3 || wr_q[k].data !== words_q[k]) begin
        n_bad++; $display("[TB] FAIL cols3_w%0d: got col%0d addr%0d, want col%0d addr%0d",
          k, wr_q[k].col, wr_q[k].addr, k % 3, 100 + k / 3);
      end
    end
  endtask

  task automatic test_core_kick;
    int vcnt, vfirst, mode_bad, fin_cyc, b;
    vcnt = 0; vfirst = -1; mode_bad = 0;
    b = $urandom_range(0, 250);
    clear_logs(); fill_words(4);
    core_ready = 1'b0;
    send_cmd(1'b0, b, 0, 4, 1'b1, 1'b1, 1'b1);
    fork
      send_words(0, 4, 1'b0);
      begin
        int guard;
        guard = 0;
        while (guard < 200) begin
          @(negedge clk); guard++;
          core_finish = 1'b0;
          if (core_valid === 1'b1) begin
            vcnt++;
            if (vcnt == 1) vfirst = cyc;
            if (core_bit_mode_i !== 1'b1 || core_is_diff_i !== 1'b1) mode_bad++;
            if (vcnt >= 6) core_ready = 1'b1;
            if (vcnt == 6) core_finish = 1'b1;
          end else if (vcnt > 0) begin
            break;
          end
        end
        core_ready = 1'b0; core_finish = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done_q.size() != 0 || busy !== 1'b1 || core_bit_mode_i !== 1'b1 || core_is_diff_i !== 1'b1) begin
      n_bad++; $display("[TB] FAIL kick_wait_fin: dones=%0d busy=%b bm=%b diff=%b, want 0/1/1/1",
        done_q.size(), busy, core_bit_mode_i, core_is_diff_i);
    end
    core_finish = 1'b1; fin_cyc = cyc + 1;
    @(negedge clk); core_finish = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (vcnt != 6 || mode_bad != 0 || vfirst != last_beat_cyc) begin
      n_bad++; $display("[TB] FAIL kick_valid: got %0d cycles from %0d bad_mode=%0d, want 6 from %0d bad_mode=0",
        vcnt, vfirst, mode_bad, last_beat_cyc);
    end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] != fin_cyc || busy !== 1'b0) begin
      n_bad++; $display("[TB] FAIL kick_done: got %0d dones (first@%0d) busy=%b, want 1 @%0d busy=0",
        done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, busy, fin_cyc);
    end
    n_cmp++;
    if (wr_q.size() != 4) begin n_bad++; $display("[TB] FAIL kick_count: got %0d, want 4", wr_q.size()); end
    for (int k = 0; k < wr_q.size() && k < 4; k++) begin
      n_cmp++;
      if (wr_q[k].bank !== 1'b0 || wr_q[k].col != k || wr_q[k].addr != b || wr_q[k].data !== words_q[k]) begin
        n_bad++; $display("[TB] FAIL kick_w%0d: got col%0d addr%0d, want col%0d addr%0d", k, wr_q[k].col, wr_q[k].addr, k, b);
      end
    end
  endtask

  task automatic test_gaps;
    int b;
    b = $urandom_range(0, 200);
    clear_logs(); fill_words(12);
    send_cmd(1'b0, b, 2, 4, 1'b0, 1'b0, 1'b0);
    fork
      send_words(0, 12, 1'b1);
      begin
        repeat (4) @(negedge clk);
        core_finish = 1'b1;
        @(negedge clk);
        core_finish = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 12) begin n_bad++; $display("[TB] FAIL gaps_count: got %0d, want 12", wr_q.size()); end
    for (int k = 0; k < wr_q.size() && k < 12; k++) begin
      n_cmp++;
      if (wr_q[k].bank !== 1'b0 || wr_q[k].col != k % 4 || wr_q[k].addr != b + k / 4 || wr_q[k].data !== words_q[k]) begin
        n_bad++; $display("[TB] FAIL gaps_w%0d: got col%0d addr%0d, want col%0d addr%0d",
          k, wr_q[k].col, wr_q[k].addr, k % 4, b + k / 4);
      end
    end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] != last_beat_cyc || busy !== 1'b0) begin
      n_bad++; $display("[TB] FAIL gaps_done: got %0d dones busy=%b, want 1 @%0d busy=0",
        done_q.size(), busy, last_beat_cyc);
    end
  endtask

  task automatic test_back_to_back;
    clear_logs(); fill_words(4);
    send_cmd(1'b0, 20, 0, 2, 1'b0, 1'b0, 1'b0);
    send_words(0, 2, 1'b0);
    n_cmp++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL b2b_ready: done=%b cmd_ready=%b, want 1/1", done, cmd_ready);
    end
    cmd_target = 1'b0; cmd_base = 8'd30; cmd_rows_m1 = 8'd0; cmd_cols = 3'd2; cmd_start = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_accept: busy=%b, want 1", busy); end
    send_words(2, 2, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 4 || done_q.size() != 2) begin
      n_bad++; $display("[TB] FAIL b2b_count: got %0d writes %0d dones, want 4/2", wr_q.size(), done_q.size());
    end
    for (int k = 0; k < wr_q.size() && k < 4; k++) begin
      n_cmp++;
      if (wr_q[k].col != k % 2 || wr_q[k].addr != ((k < 2) ? 20 : 30) || wr_q[k].data !== words_q[k]) begin
        n_bad++; $display("[TB] FAIL b2b_w%0d: got col%0d addr%0d, want col%0d addr%0d",
          k, wr_q[k].col, wr_q[k].addr, k % 2, (k < 2) ? 20 : 30);
      end
    end
  endtask

  task automatic test_max_size;
    clear_logs(); fill_words(256);
    send_cmd(1'b0, 0, 255, 1, 1'b0, 1'b0, 1'b0);
    send_words(0, 256, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 256 || done_q.size() != 1) begin
      n_bad++; $display("[TB] FAIL max_count: got %0d writes %0d dones, want 256/1", wr_q.size(), done_q.size());
    end
    for (int k = 0; k < wr_q.size() && k < 256; k++) begin
      n_cmp++;
      if (wr_q[k].col != 0 || wr_q[k].addr != k || wr_q[k].data !== words_q[k]) begin
        n_bad++; $display("[TB] FAIL max_w%0d: got col%0d addr%0d, want col0 addr%0d", k, wr_q[k].col, wr_q[k].addr, k);
      end
    end
    clear_logs();
    send_cmd(1'b0, 1, 255, 1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_q.size() != 1 || wr_q.size() != 0) begin
      n_bad++; $display("[TB] FAIL max_overflow_err: got %0d errs %0d writes, want 1/0", err_q.size(), wr_q.size());
    end
  endtask

  task automatic test_random;
    bit tgt, gaps;
    int base, rows, cols, n, eff;
    for (int it = 0; it < 8; it++) begin
      tgt  = 1'($urandom_range(0, 1));
      gaps = 1'($urandom_range(0, 1));
      base = $urandom_range(0, 255);
      rows = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
      cols = $urandom_range(0, 5);
      eff  = tgt ? (base % GD_DEPTH) : base;
      clear_logs();
      if (model_legal(tgt, base, rows, cols)) begin
        n = (rows + 1) * cols;
        fill_words(n);
        send_cmd(tgt, base, rows, cols, 1'b0, 1'b0, 1'b0);
        send_words(0, n, gaps);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_q.size() != n || done_q.size() != 1 || err_q.size() != 0) begin
          n_bad++; $display("[TB] FAIL rand%0d_count: got %0d writes %0d dones %0d errs, want %0d/1/0",
            it, wr_q.size(), done_q.size(), err_q.size(), n);
        end
        for (int k = 0; k < wr_q.size() && k < n; k++) begin
          n_cmp++;
          if (wr_q[k].bank !== tgt || wr_q[k].col != k % cols || wr_q[k].addr != eff + k / cols || wr_q[k].data !== words_q[k]) begin
            n_bad++; $display("[TB] FAIL rand%0d_w%0d: got bank%0d col%0d addr%0d, want bank%0d col%0d addr%0d",
              it, k, wr_q[k].bank, wr_q[k].col, wr_q[k].addr, tgt, k % cols, eff + k / cols);
          end
        end
      end else begin
        send_cmd(tgt, base, rows, cols, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err_q.size() != 1 || wr_q.size() != 0 || done_q.size() != 0) begin
          n_bad++; $display("[TB] FAIL rand%0d_illegal: got %0d errs %0d writes %0d dones, want 1/0/0",
            it, err_q.size(), wr_q.size(), done_q.size());
        end
      end
    end
  endtask

  task automatic test_reset_midload;
    clear_logs(); fill_words(8);
    send_cmd(1'b0, 40, 1, 4, 1'b0, 1'b0, 1'b0);
    send_words(0, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (any_out !== 1'b0) begin n_bad++; $display("[TB] FAIL midload_reset_outputs: got %b, want 0", any_out); end
    n_cmp++;
    if (wr_q.size() != 3 || done_q.size() != 0) begin
      n_bad++; $display("[TB] FAIL midload_partial: got %0d writes %0d dones, want 3/0", wr_q.size(), done_q.size());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs(); fill_words(4);
    send_cmd(1'b0, 50, 1, 2, 1'b0, 1'b0, 1'b0);
    send_words(0, 4, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 4 || done_q.size() != 1) begin
      n_bad++; $display("[TB] FAIL after_reset_count: got %0d writes %0d dones, want 4/1", wr_q.size(), done_q.size());
    end
    for (int k = 0; k < wr_q.size() && k < 4; k++) begin
      n_cmp++;
      if (wr_q[k].col != k % 2 || wr_q[k].addr != 50 + k / 2 || wr_q[k].data !== words_q[k]) begin
        n_bad++; $display("[TB] FAIL after_reset_w%0d: got col%0d addr%0d, want col%0d addr%0d",
          k, wr_q[k].col, wr_q[k].addr, k % 2, 50 + k / 2);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_target = 1'b0; cmd_base = '0; cmd_rows_m1 = '0;
    cmd_cols = '0; cmd_start = 1'b0; cmd_bit_mode = 1'b0; cmd_is_diff = 1'b0;
    s_valid = 1'b0; s_data = '0; core_ready = 1'b0; core_finish = 1'b0;
    test_reset();
    test_fm_basic();
    test_guard_bounds();
    test_bad_cols();
    test_core_kick();
    test_gaps();
    test_back_to_back();
    test_max_size();
    test_random();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
